// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and sizes for the USB TX datapath
package usb_tx_pkg;
  localparam int TX_BUF_DEPTH = 64;
  localparam int TX_OCC_W     = 7;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/tx_data_buffer_if.sv
// rtl/tx_data_buffer_if.sv - slave/encoder-facing signals of the TX byte buffer
// buffer_err exists only when TX_DATA_BUFFER_ERR_EN is defined.
interface tx_data_buffer_if;
  logic                       store_tx_data;
  usb_tx_pkg::byte_t          tx_data;
  logic                       clear;
  logic                       get_tx_packet_data;
  usb_tx_pkg::byte_t          tx_packet_data;
  logic [usb_tx_pkg::TX_OCC_W-1:0] buffer_occupancy;
  logic                       buffer_full;
  logic                       buffer_empty;
`ifdef TX_DATA_BUFFER_ERR_EN
  logic                       buffer_err;

  modport master (
    output store_tx_data, tx_data, clear, get_tx_packet_data,
    input  tx_packet_data, buffer_occupancy, buffer_full, buffer_empty, buffer_err
  );
  modport slave (
    input  store_tx_data, tx_data, clear, get_tx_packet_data,
    output tx_packet_data, buffer_occupancy, buffer_full, buffer_empty, buffer_err
  );
`else
  modport master (
    output store_tx_data, tx_data, clear, get_tx_packet_data,
    input  tx_packet_data, buffer_occupancy, buffer_full, buffer_empty
  );
  modport slave (
    input  store_tx_data, tx_data, clear, get_tx_packet_data,
    output tx_packet_data, buffer_occupancy, buffer_full, buffer_empty
  );
`endif
endinterface

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - DEPTH x 8 register array, one write port, one async read port
module fifo_regfile
  import usb_tx_pkg::*;
#(
  parameter int DEPTH = TX_BUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);
  // No reset on the array: contents are don't-care until written.
  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/tx_data_buffer.sv
// rtl/tx_data_buffer.sv - byte FIFO between AHB slave and USB TX encoder
// Optional sticky overflow/underflow flag under TX_DATA_BUFFER_ERR_EN.
module tx_data_buffer
  import usb_tx_pkg::*;
#(
  parameter int DEPTH = TX_BUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  tx_data_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [TX_OCC_W-1:0] FULL_CNT = TX_OCC_W'(DEPTH);

  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [TX_OCC_W-1:0] count;
  byte_t               out_q;
  byte_t               rdata;
  logic                pop_ok;
  logic                push_ok;
  logic                we;

  // A pop frees a slot in the same cycle, so a full buffer still takes a push.
  always_comb begin
    pop_ok  = bus.get_tx_packet_data && (count != '0);
    push_ok = bus.store_tx_data && ((count != FULL_CNT) || pop_ok);
    we      = push_ok && !bus.clear && !rst;
  end

  fifo_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (bus.tx_data),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      out_q <= '0;
    end else if (bus.clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr  <= rptr + AW'(1);
        out_q <= rdata;
      end
      if (push_ok && !pop_ok) begin
        count <= count + TX_OCC_W'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - TX_OCC_W'(1);
      end
    end
  end

`ifdef TX_DATA_BUFFER_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      err_q <= 1'b0;
    end else if ((bus.store_tx_data && !push_ok) ||
                 (bus.get_tx_packet_data && !pop_ok)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.buffer_err = err_q;
`endif

  assign bus.tx_packet_data   = out_q;
  assign bus.buffer_occupancy = count;
  assign bus.buffer_full      = (count == FULL_CNT);
  assign bus.buffer_empty     = (count == '0);
endmodule

// File: tb/tb_tx_data_buffer.sv
// tb/tb_tx_data_buffer.sv - scoreboard bench for tx_data_buffer
module tb_tx_data_buffer;
  import usb_tx_pkg::*;

  typedef struct {
    int    occ;
    logic  full;
    logic  empty;
    logic  err;
    byte_t data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  exp_t  exp_q[$];
  byte_t mq[$];
  byte_t m_tx = 8'h00;
  logic  m_err = 1'b0;

  always #5 clk = ~clk;

  tx_data_buffer_if bus();

  tx_data_buffer #(.DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the reference model is a plain byte queue.
  task automatic step(input logic r, input logic push, input byte_t d,
                      input logic pop, input logic clr);
    exp_t e;
    bit   pop_ok;
    bit   push_ok;
    @(negedge clk);
    rst                    = r;
    bus.store_tx_data      = push;
    bus.tx_data            = d;
    bus.get_tx_packet_data = pop;
    bus.clear              = clr;
    if (r) begin
      mq.delete();
      m_tx  = 8'h00;
      m_err = 1'b0;
    end else if (clr) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      pop_ok  = pop && (mq.size() > 0);
      push_ok = push && ((mq.size() < 64) || pop_ok);
      if ((pop && !pop_ok) || (push && !push_ok)) m_err = 1'b1;
      if (pop_ok) m_tx = mq.pop_front();
      if (push_ok) mq.push_back(d);
    end
    e.occ   = mq.size();
    e.full  = (mq.size() == 64);
    e.empty = (mq.size() == 0);
    e.err   = m_err;
    e.data  = m_tx;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input byte_t d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: compares DUT outputs against each queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("occupancy", int'(bus.buffer_occupancy), e.occ);
        chk("full", int'(bus.buffer_full), int'(e.full));
        chk("empty", int'(bus.buffer_empty), int'(e.empty));
        chk("tx_packet_data", int'(bus.tx_packet_data), int'(e.data));
`ifdef TX_DATA_BUFFER_ERR_EN
        chk("buffer_err", int'(bus.buffer_err), int'(e.err));
`endif
      end
    end
  end

  initial begin : stimulus
    bus.store_tx_data      = 1'b0;
    bus.tx_data            = 8'h00;
    bus.get_tx_packet_data = 1'b0;
    bus.clear              = 1'b0;

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();

    // Basic ordering.
    push(8'h11); push(8'h22); push(8'h33);
    pop(); pop(); pop();
    idle();

    // Fill, overflow, push+pop at full, then drain across the wrap.
    for (int i = 0; i < 64; i++) push(byte_t'(i));
    push(8'hAA);
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) pop();
    idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Clear with a simultaneous push, then pop on empty.
    for (int i = 0; i < 5; i++) push(byte_t'(8'hC0 + i));
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    pop();
    idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Push+pop on empty: only the push lands.
    step(1'b0, 1'b1, 8'h9C, 1'b1, 1'b0);
    pop();
    idle();

    // Push+pop at count 1.
    push(8'h41);
    step(1'b0, 1'b1, 8'h42, 1'b1, 1'b0);
    pop();

    // Reset mid-transfer.
    for (int i = 0; i < 10; i++) push(byte_t'(8'h60 + i));
    pop(); pop();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
